// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU constants: data/register-index widths, the
//                mul/div operation encoding and the mul/div FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int WIDTH   = 24;                // register file data width
    localparam int REGADDR = 4;                 // register index width
    localparam int CNTW    = $clog2(WIDTH);     // iteration counter width

    localparam logic [1:0] OP_MUL  = 2'b00;     // low word of product
    localparam logic [1:0] OP_MULH = 2'b01;     // high word of product
    localparam logic [1:0] OP_DIV  = 2'b10;     // quotient
    localparam logic [1:0] OP_REM  = 2'b11;     // remainder

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_datapath
//  Description : Iterative unsigned shift-add multiplier and restoring
//                divider. One step per enabled clock, WIDTH steps per op.
//  Ports       : Clock/Resetn  - clock, async active-low reset
//                load          - capture op/operands, clear counter/accums
//                step          - perform one iteration
//                op, opA, opB  - operation and operands (used on load)
//                lastIter      - current step is the final one
//                resultNext    - result as it will be after this step
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_datapath
    import cpu_pkg::*;
(
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             lastIter,
    output logic [WIDTH-1:0] resultNext
);

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic [2*WIDTH-1:0] r_prod;     // {partial high, remaining multiplier bits}
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;      // dividend shifts out MSB-first, quotient in
    logic [CNTW-1:0]    r_count;

    logic [WIDTH:0]     w_hiSum;
    logic [2*WIDTH-1:0] w_prodNext;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_remDiff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quoNext;

    always_comb begin
        // Multiply: add multiplicand into the high half when the LSB of the
        // multiplier is set, then shift the whole product right (carry in).
        w_hiSum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                   + (r_prod[0] ? {1'b0, r_opA} : {(WIDTH+1){1'b0}});
        w_prodNext = {w_hiSum, r_prod[WIDTH-1:1]};

        // Divide: a zero divisor always "fits", giving all-ones quotient and
        // the dividend as remainder without any special case.
        w_remShift = {r_rem, r_quo[WIDTH-1]};
        w_remDiff  = w_remShift - {1'b0, r_opB};
        w_fits     = (w_remShift >= {1'b0, r_opB});
        w_remNext  = w_fits ? w_remDiff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
        w_quoNext  = {r_quo[WIDTH-2:0], w_fits};

        case (r_op)
            OP_MUL:  resultNext = w_prodNext[WIDTH-1:0];
            OP_MULH: resultNext = w_prodNext[2*WIDTH-1:WIDTH];
            OP_DIV:  resultNext = w_quoNext;
            default: resultNext = w_remNext;
        endcase
    end

    assign lastIter = (r_count == CNTW'(WIDTH-1));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_op    <= '0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_prod  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_count <= '0;
        end else if (load) begin
            r_op    <= op;
            r_opA   <= opA;
            r_opB   <= opB;
            r_prod  <= {{WIDTH{1'b0}}, opB};
            r_rem   <= '0;
            r_quo   <= opA;
            r_count <= '0;
        end else if (step) begin
            r_prod  <= w_prodNext;
            r_rem   <= w_remNext;
            r_quo   <= w_quoNext;
            r_count <= r_count + CNTW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative 24-bit unsigned MUL/MULH/DIV/REM unit with fixed
//                WIDTH-cycle latency and a one-cycle register-file write.
//  Ports       : Clock, Resetn (async active-low)
//                Start, Op, OpA, OpB, DestIn - request (sampled in IDLE)
//                Busy            - operation in flight (CALC or DONE)
//                Done, RegWrite  - one-cycle completion/write strobe
//                Result, DestOut - held until the next completion
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import cpu_pkg::*;
(
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   OpA,
    input  logic [WIDTH-1:0]   OpB,
    input  logic [REGADDR-1:0] DestIn,
    output logic               Busy,
    output logic               Done,
    output logic               RegWrite,
    output logic [WIDTH-1:0]   Result,
    output logic [REGADDR-1:0] DestOut
);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [REGADDR-1:0] r_destCap;
    logic [REGADDR-1:0] r_destOut;

    logic               w_load;
    logic               w_step;
    logic               w_lastIter;
    logic [WIDTH-1:0]   w_resultNext;

    assign w_load = (r_state == IDLE) && Start;
    assign w_step = (r_state == CALC);

    muldiv_datapath u_datapath (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .load       (w_load),
        .step       (w_step),
        .op         (Op),
        .opA        (OpA),
        .opB        (OpB),
        .lastIter   (w_lastIter),
        .resultNext (w_resultNext)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_destCap <= '0;
            r_destOut <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_state   <= CALC;
                        r_busy    <= 1'b1;
                        r_destCap <= DestIn;
                    end
                end
                CALC: begin
                    // Final step result is taken straight from the datapath
                    // so it is valid in the DONE cycle.
                    if (w_lastIter) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_result  <= w_resultNext;
                        r_destOut <= r_destCap;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign RegWrite = r_done;
    assign Result   = r_result;
    assign DestOut  = r_destOut;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Scoreboard testbench for mul_div_unit with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import cpu_pkg::*;

    localparam int C_LAT = 24;

    logic               Clock;
    logic               Resetn;
    logic               Start;
    logic [1:0]         Op;
    logic [WIDTH-1:0]   OpA;
    logic [WIDTH-1:0]   OpB;
    logic [REGADDR-1:0] DestIn;
    logic               Busy;
    logic               Done;
    logic               RegWrite;
    logic [WIDTH-1:0]   Result;
    logic [REGADDR-1:0] DestOut;

    typedef struct {
        logic [WIDTH-1:0]   res;
        logic [REGADDR-1:0] dest;
        int                 cyc;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   accCyc = 0;

    mul_div_unit dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .Op       (Op),
        .OpA      (OpA),
        .OpB      (OpB),
        .DestIn   (DestIn),
        .Busy     (Busy),
        .Done     (Done),
        .RegWrite (RegWrite),
        .Result   (Result),
        .DestOut  (DestOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per Done pulse
    always @(negedge Clock) begin
        if (Done || RegWrite) begin
            exp_t e;
            check("regwrite_eq_done", {31'd0, RegWrite}, {31'd0, Done});
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 Result=%0h expected no Done", Result);
            end else begin
                e = expQ.pop_front();
                check("result",  {8'd0, Result},  {8'd0, e.res});
                check("destout", {28'd0, DestOut}, {28'd0, e.dest});
                check("latency", cycle, e.cyc);
            end
        end
    end

    // Issue one request; optionally push the expected response.
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [REGADDR-1:0] d,
                         input logic [WIDTH-1:0] expRes, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge Clock);
        while (Busy && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (Busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got Busy=1 expected Busy=0");
        end
        Op = op; OpA = a; OpB = b; DestIn = d; Start = 1'b1;
        @(posedge Clock);
        #1;
        accCyc = cycle;
        Start  = 1'b0;
        if (push) begin
            e.res  = expRes;
            e.dest = d;
            e.cyc  = accCyc + C_LAT;
            expQ.push_back(e);
        end
    endtask

    // Wait for all expected responses, then confirm Busy has dropped.
    task automatic waitDone(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, expQ.size());
            expQ.delete();
        end
        @(negedge Clock);
        check({name, "_busy_after"}, {31'd0, Busy}, 32'd0);
    endtask

    task automatic waitUntil(input int c);
        while (cycle < c) @(negedge Clock);
    endtask

    initial begin
        Resetn = 1'b0; Start = 1'b0; Op = OP_MUL; OpA = '0; OpB = '0; DestIn = '0;
        repeat (3) @(negedge Clock);
        check("reset_busy",     {31'd0, Busy},     32'd0);
        check("reset_done",     {31'd0, Done},     32'd0);
        check("reset_regwrite", {31'd0, RegWrite}, 32'd0);
        check("reset_result",   {8'd0, Result},    32'd0);
        check("reset_destout",  {28'd0, DestOut},  32'd0);
        Resetn = 1'b1;

        // 1: basic multiply
        issue(OP_MUL, 24'd7, 24'd6, 4'd3, 24'd42, 1'b1);
        waitDone("mul7x6");

        // 2: high/low word
        issue(OP_MULH, 24'h800000, 24'd4, 4'd5, 24'h000002, 1'b1);
        waitDone("mulh");
        issue(OP_MUL, 24'h800000, 24'd4, 4'd6, 24'h000000, 1'b1);
        waitDone("mul_low_zero");

        // 3: division
        issue(OP_DIV, 24'd100, 24'd7, 4'd7, 24'd14, 1'b1);
        waitDone("div100_7");
        issue(OP_REM, 24'd100, 24'd7, 4'd8, 24'd2, 1'b1);
        waitDone("rem100_7");
        issue(OP_DIV, 24'hFFFFFF, 24'd1, 4'd9, 24'hFFFFFF, 1'b1);
        waitDone("div_max_1");

        // 4: divide by zero
        issue(OP_DIV, 24'd5, 24'd0, 4'd10, 24'hFFFFFF, 1'b1);
        waitDone("div_by_zero");
        issue(OP_REM, 24'd5, 24'd0, 4'd11, 24'd5, 1'b1);
        waitDone("rem_by_zero");

        // 5: Start ignored while busy, including in DONE
        issue(OP_MUL, 24'd3, 24'd3, 4'd12, 24'd9, 1'b1);
        waitUntil(accCyc + 10);
        Op = OP_DIV; OpA = 24'd9; OpB = 24'd3; DestIn = 4'd13; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        waitUntil(accCyc + C_LAT);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (35) @(negedge Clock);
        check("ignore_start_busy", {31'd0, Busy}, 32'd0);
        check("ignore_start_result_held", {8'd0, Result}, 32'd9);
        check("ignore_start_queue", expQ.size(), 32'd0);

        // 6: reset mid-operation aborts
        issue(OP_MUL, 24'd11, 24'd13, 4'd14, 24'd0, 1'b0);
        waitUntil(accCyc + 12);
        Resetn = 1'b0;
        #1;
        check("abort_busy",   {31'd0, Busy},   32'd0);
        check("abort_done",   {31'd0, Done},   32'd0);
        check("abort_result", {8'd0, Result},  32'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        repeat (30) @(negedge Clock);
        check("abort_no_write_busy", {31'd0, Busy}, 32'd0);
        issue(OP_DIV, 24'd20, 24'd4, 4'd15, 24'd5, 1'b1);
        waitDone("div_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
